// File: rtl/mem_bus_pkg.sv
// Shared types and widths for the DMA/TDSP memory-bus scheduler.
package mem_bus_pkg;

    localparam int STARVE_W = 4;
    localparam int HOLD_W   = 8;
    localparam int TURN_W   = 3;

    typedef enum logic [1:0] {
        IDLE,
        GNT_DMA,
        GNT_TDSP,
        TURN
    } state_e;

    // One-shot arbitration bias left behind by a preemption.
    typedef enum logic [1:0] {
        PREF_NONE,
        PREF_DMA,
        PREF_TDSP
    } pref_e;

endpackage

// File: rtl/mem_bus_sched_if.sv
// Request/grant bundle between the bus requesters (master) and the scheduler (slave).
interface mem_bus_sched_if;

    logic dma_breq;
    logic dma_grant;
    logic tdsp_breq;
    logic tdsp_grant;
    logic bus_busy;
    logic starve_flag;

    modport master (
        output dma_breq,
        output tdsp_breq,
        input  dma_grant,
        input  tdsp_grant,
        input  bus_busy,
        input  starve_flag
    );

    modport slave (
        input  dma_breq,
        input  tdsp_breq,
        output dma_grant,
        output tdsp_grant,
        output bus_busy,
        output starve_flag
    );

endinterface

// File: rtl/sched_sat_cnt.sv
// Saturating up-counter with synchronous clear and a flag when the count equals MAX.
module sched_sat_cnt #(
    parameter int W   = 4,
    parameter int MAX = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic at_max
);

    logic [W-1:0] cnt;

    assign at_max = (cnt == W'(MAX));

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/mem_bus_sched.sv
// Two-requester memory-bus scheduler: TDSP fixed priority, DMA starvation guard, turnaround gaps.
// Optional grant-hold preemption is compiled in with `define ARB_PREEMPT_EN.
module mem_bus_sched
    import mem_bus_pkg::*;
#(
    parameter int TURNAROUND = 1,
    parameter int STARVE_MAX = 4,
    parameter int HOLD_MAX   = 16
) (
    input  logic           clk,
    input  logic           reset,
    mem_bus_sched_if.slave bus
);

    localparam logic [TURN_W-1:0] TURN_LOAD = (TURNAROUND > 0) ? TURN_W'(TURNAROUND - 1) : '0;
    localparam state_e            REL_STATE = (TURNAROUND > 0) ? TURN : IDLE;

    if (TURNAROUND < 0 || TURNAROUND > 7) begin : g_bad_turnaround
        $error("mem_bus_sched: TURNAROUND out of range 0..7");
    end
    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("mem_bus_sched: STARVE_MAX out of range 1..15");
    end
    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
        $error("mem_bus_sched: HOLD_MAX out of range 2..255");
    end

    state_e            state;
    state_e            next_state;
    logic [TURN_W-1:0] turn_cnt;
    logic              turn_load;
    logic              starve_at_max;
    logic              starve_inc;
    logic              starve_clr;
    logic              dma_wins;
    logic              release_dma;
    logic              release_tdsp;

`ifdef ARB_PREEMPT_EN
    logic  hold_at_max;
    logic  hold_clr;
    logic  hold_inc;
    logic  preempt_dma;
    logic  preempt_tdsp;
    pref_e pref;

    assign preempt_dma  = (state == GNT_DMA)  && hold_at_max && bus.tdsp_breq;
    assign preempt_tdsp = (state == GNT_TDSP) && hold_at_max && bus.dma_breq;
    assign release_dma  = !bus.dma_breq  || preempt_dma;
    assign release_tdsp = !bus.tdsp_breq || preempt_tdsp;
    // A pending preemption bias overrides both fixed priority and the starvation rule.
    assign dma_wins     = (pref == PREF_DMA) || ((pref == PREF_NONE) && starve_at_max);

    assign hold_inc = (state == GNT_DMA) || (state == GNT_TDSP);
    assign hold_clr = (state == IDLE) && ((next_state == GNT_DMA) || (next_state == GNT_TDSP));

    sched_sat_cnt #(
        .W   (HOLD_W),
        .MAX (HOLD_MAX - 1)
    ) u_hold_cnt (
        .clk    (clk),
        .reset  (reset),
        .clr    (hold_clr),
        .inc    (hold_inc),
        .at_max (hold_at_max)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pref <= PREF_NONE;
        end else if (preempt_dma) begin
            pref <= PREF_TDSP;
        end else if (preempt_tdsp) begin
            pref <= PREF_DMA;
        end else if ((state == IDLE) && (next_state != IDLE)) begin
            pref <= PREF_NONE;
        end
    end
`else
    assign release_dma  = !bus.dma_breq;
    assign release_tdsp = !bus.tdsp_breq;
    assign dma_wins     = starve_at_max;
`endif

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        next_state = state;
        turn_load  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.dma_breq && bus.tdsp_breq) begin
                    next_state = dma_wins ? GNT_DMA : GNT_TDSP;
                end else if (bus.tdsp_breq) begin
                    next_state = GNT_TDSP;
                end else if (bus.dma_breq) begin
                    next_state = GNT_DMA;
                end
            end
            GNT_DMA: begin
                if (release_dma) begin
                    next_state = REL_STATE;
                    turn_load  = 1'b1;
                end
            end
            GNT_TDSP: begin
                if (release_tdsp) begin
                    next_state = REL_STATE;
                    turn_load  = 1'b1;
                end
            end
            TURN: begin
                if (turn_cnt == '0) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            turn_cnt <= '0;
        end else begin
            state <= next_state;
            if (turn_load) begin
                turn_cnt <= TURN_LOAD;
            end else if ((state == TURN) && (turn_cnt != '0)) begin
                turn_cnt <= turn_cnt - 1'b1;
            end
        end
    end

    // Grants only ever start from IDLE, so entry detection is a simple IDLE-exit decode.
    assign starve_inc = (state == IDLE) && (next_state == GNT_TDSP) && bus.dma_breq;
    assign starve_clr = (state == IDLE) && (next_state == GNT_DMA);

    sched_sat_cnt #(
        .W   (STARVE_W),
        .MAX (STARVE_MAX)
    ) u_starve_cnt (
        .clk    (clk),
        .reset  (reset),
        .clr    (starve_clr),
        .inc    (starve_inc),
        .at_max (starve_at_max)
    );

    assign bus.dma_grant   = (state == GNT_DMA);
    assign bus.tdsp_grant  = (state == GNT_TDSP);
    assign bus.bus_busy    = (state != IDLE);
    assign bus.starve_flag = starve_at_max;

    a_grant_excl: assert property (@(posedge clk) disable iff (!reset)
        !(bus.dma_grant && bus.tdsp_grant));

endmodule

// File: tb/tb_mem_bus_sched.sv
// Directed bench for mem_bus_sched (TURNAROUND=1, STARVE_MAX=4, HOLD_MAX=16).
module tb_mem_bus_sched;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    mem_bus_sched_if bus();

    mem_bus_sched #(
        .TURNAROUND (1),
        .STARVE_MAX (4),
        .HOLD_MAX   (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // {dma_grant, tdsp_grant, bus_busy}
    logic [2:0] obs;
    assign obs = {bus.dma_grant, bus.tdsp_grant, bus.bus_busy};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        bus.dma_breq = 1'b1;
        bus.tdsp_breq = 1'b1;
        repeat (3) tick();
        tests++; if (obs !== 3'b000) begin fails++; $display("FAIL reset_hold obs=%b exp=000", obs); end
        tests++; if (bus.starve_flag !== 1'b0) begin fails++; $display("FAIL reset_starve got=%b exp=0", bus.starve_flag); end
        @(negedge clk);
        reset = 1'b1;
        tick();
        tests++; if (obs !== 3'b011) begin fails++; $display("FAIL reset_release obs=%b exp=011", obs); end
        bus.dma_breq = 1'b0;
        bus.tdsp_breq = 1'b0;
        tick();
        tests++; if (obs !== 3'b001) begin fails++; $display("FAIL reset_turn obs=%b exp=001", obs); end
        tick();
        tests++; if (obs !== 3'b000) begin fails++; $display("FAIL reset_idle obs=%b exp=000", obs); end
    endtask

    task automatic test_dma_alone;
        bus.dma_breq = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++; if (obs !== 3'b101) begin fails++; $display("FAIL dma_alone_grant cyc=%0d obs=%b exp=101", i, obs); end
        end
        bus.dma_breq = 1'b0;
        tick();
        tests++; if (obs !== 3'b001) begin fails++; $display("FAIL dma_alone_turn obs=%b exp=001", obs); end
        tick();
        tests++; if (obs !== 3'b000) begin fails++; $display("FAIL dma_alone_idle obs=%b exp=000", obs); end
    endtask

    task automatic test_simultaneous;
        bus.dma_breq = 1'b1;
        bus.tdsp_breq = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++; if (obs !== 3'b011) begin fails++; $display("FAIL simul_tdsp cyc=%0d obs=%b exp=011", i, obs); end
        end
        bus.tdsp_breq = 1'b0;
        tick();
        tests++; if (obs !== 3'b001) begin fails++; $display("FAIL simul_turn obs=%b exp=001", obs); end
        tick();
        tests++; if (obs !== 3'b000) begin fails++; $display("FAIL simul_idle obs=%b exp=000", obs); end
        tick();
        tests++; if (obs !== 3'b101) begin fails++; $display("FAIL simul_dma obs=%b exp=101", obs); end
        bus.dma_breq = 1'b0;
        repeat (2) tick();
        tests++; if (obs !== 3'b000) begin fails++; $display("FAIL simul_end obs=%b exp=000", obs); end
    endtask

    task automatic test_one_cycle_grant;
        bus.tdsp_breq = 1'b1;
        tick();
        tests++; if (obs !== 3'b011) begin fails++; $display("FAIL short_grant obs=%b exp=011", obs); end
        bus.tdsp_breq = 1'b0;
        tick();
        tests++; if (obs !== 3'b001) begin fails++; $display("FAIL short_release obs=%b exp=001", obs); end
        bus.dma_breq = 1'b1;
        tick();
        tests++; if (obs !== 3'b000) begin fails++; $display("FAIL turn_req_idle obs=%b exp=000", obs); end
        tick();
        tests++; if (obs !== 3'b101) begin fails++; $display("FAIL turn_req_grant obs=%b exp=101", obs); end
        bus.dma_breq = 1'b0;
        repeat (2) tick();
        tests++; if (obs !== 3'b000) begin fails++; $display("FAIL short_end obs=%b exp=000", obs); end
    endtask

    task automatic test_starvation;
        bus.dma_breq = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.tdsp_breq = 1'b1;
            tick();
            tests++; if (obs !== 3'b011) begin fails++; $display("FAIL starve_tdsp k=%0d obs=%b exp=011", k, obs); end
            tests++; if (bus.starve_flag !== (k == 3)) begin fails++; $display("FAIL starve_flag k=%0d got=%b exp=%b", k, bus.starve_flag, (k == 3)); end
            tick();
            bus.tdsp_breq = 1'b0;
            repeat (2) tick();
        end
        bus.tdsp_breq = 1'b1;
        tick();
        tests++; if (obs !== 3'b101) begin fails++; $display("FAIL starve_promote obs=%b exp=101", obs); end
        tests++; if (bus.starve_flag !== 1'b0) begin fails++; $display("FAIL starve_clear got=%b exp=0", bus.starve_flag); end
        bus.dma_breq = 1'b0;
        bus.tdsp_breq = 1'b0;
        repeat (2) tick();
        tests++; if (obs !== 3'b000) begin fails++; $display("FAIL starve_end obs=%b exp=000", obs); end
    endtask

    task automatic test_async_reset;
        bus.dma_breq = 1'b1;
        tick();
        tests++; if (obs !== 3'b101) begin fails++; $display("FAIL areset_pre obs=%b exp=101", obs); end
        #2;
        reset = 1'b0;
        #1;
        tests++; if (obs !== 3'b000) begin fails++; $display("FAIL areset_immediate obs=%b exp=000", obs); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        tests++; if (obs !== 3'b000) begin fails++; $display("FAIL areset_no_retain obs=%b exp=000", obs); end
        tick();
        tests++; if (obs !== 3'b101) begin fails++; $display("FAIL areset_rearb obs=%b exp=101", obs); end
        bus.dma_breq = 1'b0;
        repeat (2) tick();
        tests++; if (obs !== 3'b000) begin fails++; $display("FAIL areset_end obs=%b exp=000", obs); end
    endtask

`ifdef ARB_PREEMPT_EN
    task automatic test_preempt;
        int held;
        held = 0;
        bus.dma_breq = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i == 3) bus.tdsp_breq = 1'b1;
            if (bus.dma_grant) held++;
            else break;
        end
        tests++; if (held !== 16) begin fails++; $display("FAIL preempt_hold got=%0d exp=16", held); end
        tests++; if (obs !== 3'b001) begin fails++; $display("FAIL preempt_turn obs=%b exp=001", obs); end
        repeat (2) tick();
        tests++; if (obs !== 3'b011) begin fails++; $display("FAIL preempt_tdsp obs=%b exp=011", obs); end
        tick();
        bus.tdsp_breq = 1'b0;
        repeat (3) tick();
        tests++; if (obs !== 3'b101) begin fails++; $display("FAIL preempt_regrant obs=%b exp=101", obs); end
        bus.dma_breq = 1'b0;
        repeat (2) tick();
    endtask
`endif

    initial begin
        test_reset();
        test_dma_alone();
        test_simultaneous();
        test_one_cycle_grant();
        test_starvation();
        test_async_reset();
`ifdef ARB_PREEMPT_EN
        test_preempt();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout tests=%0d", tests);
        $fatal(1, "watchdog expired");
    end

endmodule
